// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and
// the layout of the tagged output word.
package reg_dump_ctrl_pkg;

    localparam int DUMP_N = 16;
    localparam int DUMP_M = 3;

    // Tagged word: {is_sum, index, value}
    localparam int WORD_W     = DUMP_N + DUMP_M + 1;
    localparam int IS_SUM_BIT = WORD_W - 1;
    localparam int IDX_MSB    = WORD_W - 2;
    localparam int IDX_LSB    = DUMP_N;
    localparam int VAL_MSB    = DUMP_N - 1;
    localparam int VAL_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_SUM     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Valid/ready stream carrying tagged dump words to the debug consumer.
interface reg_dump_ctrl_if #(
    parameter int N = 16,
    parameter int M = 3
);
    logic [N+M:0] Word_out;
    logic         Word_valid;
    logic         Word_ready;

    modport master (output Word_out, output Word_valid, input Word_ready);
    modport slave  (input Word_out, input Word_valid, output Word_ready);
endinterface

// File: rtl/reg_dump_ctrl_dump_word_reg.sv
// Output word register: captures a word on load and holds it, with valid
// asserted, for as long as the controller keeps the word pending.
module dump_word_reg #(
    parameter int W = 20
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic         keep,
    input  logic [W-1:0] word_in,
    output logic [W-1:0] word_out,
    output logic         valid_out
);

    logic [W-1:0] word_q, word_d;
    logic         valid_q, valid_d;

    // Load replaces the word; otherwise hold it, dropping valid when released
    always_comb begin
        word_d  = word_q;
        valid_d = 1'b0;
        if (load) begin
            word_d  = word_in;
            valid_d = 1'b1;
        end else if (keep) begin
            valid_d = valid_q;
        end
    end

    // Word and valid registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_out  = word_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Debug reader for the register file inspection port. Walks one register or
// all of them, streams tagged words and ends a full dump with an XOR checksum.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for Start
// SELECT  | index presented to the register file, inr_check high
// CAPTURE | outvalue captured into the word register and the checksum
// SEND    | data word offered, held until accepted
// SUM     | checksum word offered (full dump only)
// DONE    | one-cycle completion pulse
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int N = DUMP_N,
    parameter int M = DUMP_M
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [M-1:0]  Sel_reg,
    input  logic          Abort,
    input  logic [N-1:0]  outvalue,
    output logic [M-1:0]  inr,
    output logic          inr_check,
    output logic          Busy,
    output logic          Done,
    reg_dump_ctrl_if.master word_if
);

    state_t         state_q, state_d;
    logic [M-1:0]   idx_q, idx_d;
    logic [N-1:0]   csum_q, csum_d;
    logic           mode_q, mode_d;
    logic           inr_check_q, inr_check_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           handshake;
    logic           last_idx;
    logic           word_load;
    logic           word_keep;
    logic [N+M:0]   word_in;

    assign handshake = word_if.Word_valid & word_if.Word_ready;
    assign last_idx  = (idx_q == {M{1'b1}});

    // Next-state, index and checksum; Abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    mode_d  = Mode;
                    idx_d   = Mode ? '0 : Sel_reg;
                    csum_d  = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT:  state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                csum_d  = csum_q ^ outvalue;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (!mode_q) begin
                        state_d = ST_DONE;
                    end else if (last_idx) begin
                        state_d = ST_SUM;
                    end else begin
                        idx_d   = idx_q + {{(M-1){1'b0}}, 1'b1};
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SUM: begin
                if (handshake) state_d = ST_DONE;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (Abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            csum_d  = csum_q;
        end
    end

    // Registered outputs follow the state being entered, so they line up with it
    always_comb begin
        inr_check_d = (state_d == ST_SELECT) || (state_d == ST_CAPTURE) ||
                      (state_d == ST_SEND);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        word_keep   = (state_d == ST_SEND) || (state_d == ST_SUM);
        word_load   = word_keep && (state_d != state_q);
        // The data word is built from outvalue directly: it is the value being
        // captured on the same edge that enters SEND.
        word_in     = (state_d == ST_SUM) ? {1'b1, {M{1'b0}}, csum_q}
                                          : {1'b0, idx_q, outvalue};
    end

    // Control and datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            mode_q      <= 1'b0;
            inr_check_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            mode_q      <= mode_d;
            inr_check_q <= inr_check_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    dump_word_reg #(.W(N + M + 1)) u_word_reg (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (word_load),
        .keep      (word_keep),
        .word_in   (word_in),
        .word_out  (word_if.Word_out),
        .valid_out (word_if.Word_valid)
    );

    assign inr       = idx_q;
    assign inr_check = inr_check_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: a reference model pushes expected words,
// a monitor pops and compares them at every handshake.
module tb_reg_dump_ctrl;
    import reg_dump_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Mode;
    logic [2:0]  Sel_reg;
    logic        Abort;
    logic [15:0] outvalue;
    logic [2:0]  inr;
    logic        inr_check;
    logic        Busy;
    logic        Done;

    logic [15:0] rf [8];
    logic [19:0] exp_q [$];
    int          n_pass;
    int          n_total;
    int          cyc;
    int          done_cnt;

    reg_dump_ctrl_if #(.N(16), .M(3)) wif ();

    reg_dump_ctrl #(.N(16), .M(3)) dut (
        .Clock     (clk),
        .Reset     (rst_n),
        .Start     (Start),
        .Mode      (Mode),
        .Sel_reg   (Sel_reg),
        .Abort     (Abort),
        .outvalue  (outvalue),
        .inr       (inr),
        .inr_check (inr_check),
        .Busy      (Busy),
        .Done      (Done),
        .word_if   (wif.master)
    );

    assign outvalue = rf[inr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Monitor: a word is accepted on the coming edge when valid, ready and no Abort
    always @(negedge clk) begin
        if (rst_n && Done) done_cnt++;
        if (rst_n && wif.Word_valid && wif.Word_ready && !Abort) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {12'h0, wif.Word_out}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("word", {12'h0, wif.Word_out}, {12'h0, e});
            end
        end
    end

    // Reference model: the words a dump must produce, in order
    task automatic model_push(input bit mode, input logic [2:0] sel, input int abort_idx);
        logic [15:0] sum;
        sum = '0;
        if (!mode) begin
            exp_q.push_back({1'b0, sel, rf[sel]});
        end else begin
            for (int i = 0; i < 8; i++) begin
                sum = sum ^ rf[i];
                if (abort_idx < 0 || i < abort_idx) exp_q.push_back({1'b0, 3'(i), rf[i]});
            end
            if (abort_idx < 0) exp_q.push_back({1'b1, 3'b000, sum});
        end
    endtask

    task automatic run_dump(input bit mode, input logic [2:0] sel, input int stall_idx,
                            input int stall_len, input int abort_idx, input bit rnd_ready,
                            input bit poke_start);
        int  e, first_vld, done_at, stalls, stall_cnt, dc0, abort_at, base;
        bit  inr_ok;
        model_push(mode, sel, abort_idx);
        dc0 = done_cnt; stalls = 0; stall_cnt = 0;
        first_vld = -1; done_at = -1; abort_at = -1; inr_ok = 1'b1;
        base = mode ? 25 : 3;

        @(posedge clk); #2;
        Start = 1'b1; Mode = mode; Sel_reg = sel; wif.Word_ready = 1'b1;
        @(posedge clk); #2;
        e = cyc;
        Start = 1'b0; Mode = 1'($urandom); Sel_reg = 3'($urandom);
        @(negedge clk);
        chk("busy_at_E", {31'h0, Busy}, 32'd1);
        chk("inr_check_at_E", {31'h0, inr_check}, 32'd1);
        chk("inr_at_E", {29'h0, inr}, {29'h0, (mode ? 3'd0 : sel)});

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            Abort = 1'b0;
            if (first_vld < 0 && wif.Word_valid) first_vld = cyc - e;
            if (abort_idx >= 0 && abort_at < 0 && wif.Word_valid && !wif.Word_out[IS_SUM_BIT]
                && wif.Word_out[IDX_MSB:IDX_LSB] == 3'(abort_idx)) begin
                Abort = 1'b1; wif.Word_ready = 1'b1; abort_at = cyc;
            end else if (stall_idx >= 0 && wif.Word_valid && !wif.Word_out[IS_SUM_BIT]
                && wif.Word_out[IDX_MSB:IDX_LSB] == 3'(stall_idx) && stall_cnt < stall_len) begin
                wif.Word_ready = 1'b0; stall_cnt++;
            end else begin
                wif.Word_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            Start = (poke_start && (c == 6 || c == 14)) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (wif.Word_valid && !wif.Word_ready) stalls++;
            if (inr_check && !mode && inr !== sel) inr_ok = 1'b0;
            if (Done) begin done_at = cyc - e; break; end
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk("abort_busy", {31'h0, Busy}, 32'd0);
                chk("abort_valid", {31'h0, wif.Word_valid}, 32'd0);
                chk("abort_inr_check", {31'h0, inr_check}, 32'd0);
            end
            if (abort_at >= 0 && cyc == abort_at + 4) break;
        end
        Abort = 1'b0; Start = 1'b0;

        if (abort_idx < 0) begin
            chk("done_time", done_at, base + stalls);
            chk("first_valid", first_vld, 32'd2);
            @(negedge clk);
            chk("done_one_cycle", {31'h0, Done}, 32'd0);
            chk("idle_after_done", {31'h0, Busy}, 32'd0);
            @(negedge clk);
            chk("start_not_queued", {31'h0, Busy}, 32'd0);
        end else begin
            chk("no_done_on_abort", done_cnt - dc0, 32'd0);
        end
        if (!mode) chk("inr_stable", {31'h0, inr_ok}, 32'd1);
        chk("sb_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_mid_dump();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111 + 16'h0101);
        model_push(1'b1, 3'd0, -1);
        @(posedge clk); #2;
        Start = 1'b1; Mode = 1'b1; wif.Word_ready = 1'b1;
        @(posedge clk); #2;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_inr", {29'h0, inr}, 32'd0);
        chk("rst_inr_check", {31'h0, inr_check}, 32'd0);
        chk("rst_word_out", {12'h0, wif.Word_out}, 32'd0);
        chk("rst_valid", {31'h0, wif.Word_valid}, 32'd0);
        chk("rst_busy", {31'h0, Busy}, 32'd0);
        chk("rst_done", {31'h0, Done}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'h0, Busy}, 32'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; done_cnt = 0;
        rst_n = 1'b0; Start = 1'b0; Mode = 1'b0; Sel_reg = 3'd0; Abort = 1'b0;
        wif.Word_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        #1;
        chk("reset_inr", {29'h0, inr}, 32'd0);
        chk("reset_inr_check", {31'h0, inr_check}, 32'd0);
        chk("reset_word_out", {12'h0, wif.Word_out}, 32'd0);
        chk("reset_valid", {31'h0, wif.Word_valid}, 32'd0);
        chk("reset_busy", {31'h0, Busy}, 32'd0);
        chk("reset_done", {31'h0, Done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single register: expects word 0x10003, Done at E+3
        rf[1] = 16'd3;
        run_dump(1'b0, 3'd1, -1, 0, -1, 1'b0, 1'b0);

        // Full dump 7,3,0..: checksum word 0x80004, Done at E+25
        rf[0] = 16'd7; rf[1] = 16'd3;
        for (int i = 2; i < 8; i++) rf[i] = '0;
        run_dump(1'b1, 3'd0, -1, 0, -1, 1'b0, 1'b0);

        // Five-cycle stall on index 2
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        run_dump(1'b1, 3'd0, 2, 5, -1, 1'b0, 1'b0);

        // Abort in SEND of index 4 with ready high, then a fresh dump
        run_dump(1'b1, 3'd0, -1, 0, 4, 1'b0, 1'b0);
        run_dump(1'b1, 3'd0, -1, 0, -1, 1'b0, 1'b0);

        // Asynchronous reset mid-dump
        reset_mid_dump();

        // Start pulsed while busy must be ignored
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        run_dump(1'b1, 3'd0, -1, 0, -1, 1'b1, 1'b1);

        // Random dumps with random back-pressure
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            run_dump(1'($urandom), 3'($urandom), -1, 0, -1, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Debug reader for the CPU register file's inspection port. On a start request it drives `inr`/`inr_check` to walk one register or all eight, captures each returned `outvalue`, and streams tagged words to a debug consumer over a valid/ready handshake. A full dump ends with an XOR checksum word. The block sits beside the register file and drives only its inspection port, never its read or write ports.

## Interface
Parameters:
- `N`, 16, register data width; must match the register file.
- `M`, 3, register index width; the register count is 2^M.

Ports:
- `Clock`, in, 1, the single system clock; all state changes on its rising edge.
- `Reset`, in, 1, asynchronous, active-low reset; drives all state and outputs to their reset values immediately.
- `Start`, in, 1, dump request; sampled only in IDLE.
- `Mode`, in, 1, 0 = dump the single register `Sel_reg`, 1 = dump all registers in ascending order; captured at the accepted Start.
- `Sel_reg`, in, M, register index for Mode 0; captured at the accepted Start.
- `Abort`, in, 1, synchronous cancel.
- `outvalue`, in, N, register value returned by the register file for the current `inr`.
- `inr`, out, M, register index presented to the register file; registered.
- `inr_check`, out, 1, inspection enable to the register file; registered.
- `Word_out`, out, N+M+1, tagged word: bit N+M = `is_sum`, bits N+M-1:N = register index, bits N-1:0 = value.
- `Word_valid`, out, 1, `Word_out` is valid.
- `Word_ready`, in, 1, consumer accepts the word.
- `Busy`, out, 1, high in every state except IDLE.
- `Done`, out, 1, one-cycle pulse when a dump completes normally.

## Operation
- State machine states: IDLE, SELECT, CAPTURE, SEND, SUM, DONE.
- IDLE: `Start`=1 latches `Mode` and the first index (`Sel_reg` in Mode 0, 0 in Mode 1), clears the checksum, and moves to SELECT.
- SELECT: `inr` = current index, `inr_check` = 1. Moves to CAPTURE.
- CAPTURE: `inr_check` stays 1. On this edge the block latches `outvalue` into the data register and XORs it into the checksum. Moves to SEND.
- SEND: `Word_valid` = 1 and `Word_out` = {0, index, data}. `Word_out` stays stable until the handshake.
  - Handshake occurs when `Word_valid` and `Word_ready` are both high on a rising edge.
  - After the handshake: Mode 0 goes to DONE. Mode 1 with index < 2^M-1 increments the index and goes to SELECT. Mode 1 with the last index goes to SUM.
- SUM: `Word_valid` = 1 and `Word_out` = {1, 0, checksum}. The handshake moves the FSM to DONE.
- DONE: `Done` = 1 for exactly one cycle, `inr_check` = 0, then IDLE.
- `inr_check` is 1 only in SELECT, CAPTURE and SEND. `inr` holds its last value otherwise.
- Checksum is the N-bit XOR of all captured values; there is no carry.
- Index increments within M bits and never wraps during a dump; the last index is detected before the increment.
- `Start` while `Busy` is ignored and not queued.
- `Abort`=1 in any non-IDLE state sends the FSM to IDLE on the next edge.
  - The current word is dropped, even if `Word_ready` is high on that same edge; Abort wins over the handshake.
  - No `Done` pulse; `Word_valid` and `inr_check` fall at that edge.
- `Abort` and `Start` together in IDLE: Start is ignored.
- `Word_ready` outside SEND/SUM has no effect.

## Timing
- Reset values: `inr`=0, `inr_check`=0, `Word_out`=0, `Word_valid`=0, `Busy`=0, `Done`=0, FSM in IDLE, checksum 0.
- Reset asserted mid-dump: all of the above apply immediately, without waiting for a clock edge.
- Start accepted at edge E:
  - `Busy` and `inr_check` are high from E.
  - `Word_valid` rises at E+2.
- Each register costs 3 cycles plus any `Word_ready` stall cycles.
- Mode 1 with `Word_ready` held high:
  - Last data word accepted at E+24.
  - SUM word valid in cycle E+24 and accepted at E+25.
  - `Done` high in cycle E+25; IDLE from E+26.
- Mode 0 with `Word_ready` high: `Done` high in cycle E+3.
- Back-to-back dumps: a Start is accepted at the earliest on the first IDLE cycle after DONE.

## Structure
- A shared package holds:
  - the FSM state encoding;
  - the word field positions (`IS_SUM_BIT`, index and value field bounds);
  - the `Word_out` width localparam N+M+1.
- One sub-module is natural: `dump_word_reg`, the output word register with hold-until-handshake behaviour, reused by both SEND and SUM.
- The rest is a single FSM with index counter and checksum registers.

## Test plan
- Mode 0, `Sel_reg`=1, reg_1=3, `Word_ready`=1: exactly one word 0x10003 (is_sum=0, index=1, value=3), `Done` at E+3, `inr`=1 during the dump.
- Mode 1, registers 0..7 = 7,3,0,0,0,0,0,0, `Word_ready`=1: words index 0..7 in order with these values, then SUM word 0x80004 (7 XOR 3 = 4), `Done` at E+25.
- Mode 1 with `Word_ready` low for 5 cycles on index 2: `Word_out` stable throughout, no duplicated or skipped index, `Done` delayed by exactly 5 cycles.
- `Abort` raised in SEND for index 4 with `Word_ready`=1 on the same edge: no word accepted for index 4, no SUM word, no `Done`, IDLE next cycle; a new Start then dumps from index 0 with a fresh checksum.
- Reset driven low mid-dump, asynchronously between edges: all outputs go to their reset values before the next edge; `Start` pulsed during `Busy` is ignored.
